// File: rtl/seven_seg_mux_if.sv
// Display bus between the BCD source and the 4-digit common-anode display driver.
// The master drives the digits and decimal-point mask; the slave drives the display pins.
interface seven_seg_mux_if;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] dp_mask;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       dp;
    logic       frame_start;

    modport master (
        output digit0, digit1, digit2, digit3, dp_mask,
        input  anode, segment, dp, frame_start
    );

    modport slave (
        input  digit0, digit1, digit2, digit3, dp_mask,
        output anode, segment, dp, frame_start
    );
endinterface

// File: rtl/seven_seg_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with per-frame snapshot and guard band.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module seven_seg_mux #(
    parameter int unsigned COUNT_BITS    = 17,
    parameter int unsigned REFRESH_TICKS = 100000,
    parameter int unsigned BLANK_TICKS   = 2
) (
    input  logic            clk,
    input  logic            reset,
    seven_seg_mux_if.slave  disp
);

    localparam logic [COUNT_BITS-1:0] LAST_TICK = COUNT_BITS'(REFRESH_TICKS - 1);
    localparam logic [COUNT_BITS-1:0] BLANK_END = COUNT_BITS'(BLANK_TICKS);
    localparam logic [3:0]            ANODE_OFF = 4'hF;
    localparam logic [6:0]            SEG_OFF   = 7'h7F;

    logic [COUNT_BITS-1:0] tick_count_q, tick_count_d;
    logic [1:0]            digit_sel_q, digit_sel_d;
    logic [3:0][3:0]       snap_digit_q, snap_digit_d;
    logic [3:0]            snap_dp_q, snap_dp_d;
    logic [3:0]            anode_q, anode_d;
    logic [6:0]            segment_q, segment_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q, frame_start_d;

    logic                  last_tick;
    logic                  slot_blank;
    logic [3:0]            cur_digit;

    // Active-low hex decode; anything outside 0-9 shows a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    always_comb begin
        tick_count_d  = tick_count_q + COUNT_BITS'(1);
        digit_sel_d   = digit_sel_q;
        snap_digit_d  = snap_digit_q;
        snap_dp_d     = snap_dp_q;
        anode_d       = ANODE_OFF;
        segment_d     = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;
        slot_blank    = 1'b0;
        cur_digit     = snap_digit_q[digit_sel_q];
        last_tick     = (tick_count_q == LAST_TICK);

        // Slot/frame sequencing; snapshot taken only at the frame boundary to avoid tearing.
        if (last_tick) begin
            tick_count_d = '0;
            digit_sel_d  = digit_sel_q + 2'd1;
            if (digit_sel_q == 2'd3) begin
                snap_digit_d  = {disp.digit3, disp.digit2, disp.digit1, disp.digit0};
                snap_dp_d     = disp.dp_mask;
                frame_start_d = 1'b1;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        case (digit_sel_q)
            2'd3:    slot_blank = (snap_digit_q[3] == 4'd0);
            2'd2:    slot_blank = (snap_digit_q[3] == 4'd0) && (snap_digit_q[2] == 4'd0);
            2'd1:    slot_blank = (snap_digit_q[3] == 4'd0) && (snap_digit_q[2] == 4'd0)
                                  && (snap_digit_q[1] == 4'd0);
            default: slot_blank = 1'b0;
        endcase
`else
        slot_blank = 1'b0;
`endif

        // Guard band at each slot start keeps the previous digit from ghosting.
        if ((tick_count_q >= BLANK_END) && !slot_blank) begin
            anode_d   = ~(4'b0001 << digit_sel_q);
            segment_d = bcd_to_seg(cur_digit);
            dp_d      = ~snap_dp_q[digit_sel_q];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_count_q  <= '0;
            digit_sel_q   <= 2'd0;
            snap_digit_q  <= '0;
            snap_dp_q     <= 4'd0;
            anode_q       <= ANODE_OFF;
            segment_q     <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            tick_count_q  <= tick_count_d;
            digit_sel_q   <= digit_sel_d;
            snap_digit_q  <= snap_digit_d;
            snap_dp_q     <= snap_dp_d;
            anode_q       <= anode_d;
            segment_q     <= segment_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign disp.anode       = anode_q;
    assign disp.segment     = segment_q;
    assign disp.dp          = dp_q;
    assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Scoreboard bench for seven_seg_mux: each frame's expected pin sequence is queued when digits are driven.
// Build with LEADING_ZERO_BLANK_EN defined to cover leading-zero suppression.
module tb_seven_seg_mux;

    localparam int unsigned RT    = 8;
    localparam int unsigned BT    = 2;
    localparam int unsigned FRAME = 4 * RT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } pins_t;

    localparam pins_t RST_PINS = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};

    logic  clk = 1'b0;
    logic  reset = 1'b0;
    pins_t sb[$];
    pins_t got, exp_p;
    int    checks = 0;
    int    errors = 0;

    seven_seg_mux_if bus ();

    seven_seg_mux #(
        .COUNT_BITS   (4),
        .REFRESH_TICKS(RT),
        .BLANK_TICKS  (BT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .disp (bus)
    );

    always #5 clk = ~clk;

    function automatic pins_t sample_pins();
        pins_t p;
        p.an  = bus.anode;
        p.seg = bus.segment;
        p.dp  = bus.dp;
        p.fs  = bus.frame_start;
        return p;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // Expected pins for one frame, one entry per cycle, aligned to the cycle after frame_start.
    task automatic push_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic [3:0] dpm);
        logic [3:0] d [4];
        logic [3:0] blank;
        pins_t      e;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (d3 == 4'd0);
        blank[2] = blank[3] && (d2 == 4'd0);
        blank[1] = blank[2] && (d1 == 4'd0);
`endif
        for (int s = 0; s < 4; s++) begin
            for (int t = 0; t < int'(RT); t++) begin
                e = RST_PINS;
                if (t >= int'(BT) && !blank[s]) begin
                    e.an  = ~(4'b0001 << s);
                    e.seg = seg_of(d[s]);
                    e.dp  = ~dpm[s];
                end
                e.fs = (s == 3) && (t == int'(RT) - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic drive_digits(input logic [3:0] d0, input logic [3:0] d1,
                                input logic [3:0] d2, input logic [3:0] d3,
                                input logic [3:0] dpm);
        bus.digit0  = d0;
        bus.digit1  = d1;
        bus.digit2  = d2;
        bus.digit3  = d3;
        bus.dp_mask = dpm;
        push_frame(d0, d1, d2, d3, dpm);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        got = sample_pins();
        checks++;
        if (got !== RST_PINS) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=%h", got, RST_PINS);
        end
        reset = 1'b1;
        repeat (13) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = sample_pins();
            checks++;
            if (got !== RST_PINS) begin
                errors++;
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, RST_PINS);
            end
        end
        reset = 1'b1;
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        drive_digits(4'd7, 4'd0, 4'd9, 4'd5, 4'b0100);
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL first_frame[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
        end
    endtask

    task automatic test_snapshot();
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL snapshot[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
            // Change digit0 while the anode=D slot is on screen.
            if (i == 12) drive_digits(4'd3, 4'd0, 4'd9, 4'd5, 4'b0100);
        end
    endtask

    task automatic test_tearing();
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL tearing[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
            if (i == 5) drive_digits(4'd3, 4'hC, 4'd9, 4'd5, 4'b0100);
        end
    endtask

    task automatic test_invalid_bcd();
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL invalid_bcd[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
            if (i == 20) drive_digits(4'd0, 4'd4, 4'd0, 4'd0, 4'b0000);
        end
    endtask

    task automatic test_leading_zero();
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL leading_zero[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
            if (i == 9) drive_digits(4'd4, 4'd3, 4'd2, 4'd1, 4'b0001);
        end
    endtask

    task automatic test_reset_mid();
        // 21 edges after frame start puts the counter at digit_sel=2, tick_count=5.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL pre_reset[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
        end
        reset = 1'b0;
        #1;
        got = sample_pins();
        checks++;
        if (got !== RST_PINS) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", got, RST_PINS);
        end
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = sample_pins();
            checks++;
            if (got !== RST_PINS) begin
                errors++;
                $display("FAIL reset_mid_hold[%0d] got=%h exp=%h", i, got, RST_PINS);
            end
        end
        reset = 1'b1;
        push_frame(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
        for (int i = 0; i < int'(FRAME); i++) begin
            @(negedge clk);
            got   = sample_pins();
            exp_p = sb.pop_front();
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL restart[%0d] got an=%h seg=%h dp=%b fs=%b exp an=%h seg=%h dp=%b fs=%b",
                         i, got.an, got.seg, got.dp, got.fs, exp_p.an, exp_p.seg, exp_p.dp, exp_p.fs);
            end
        end
    endtask

    initial begin
        bus.digit0  = 4'd0;
        bus.digit1  = 4'd0;
        bus.digit2  = 4'd0;
        bus.digit3  = 4'd0;
        bus.dp_mask = 4'b0000;
        test_reset();
        test_snapshot();
        test_tearing();
        test_invalid_bcd();
        test_leading_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
- Time-multiplexed 4-digit, 7-segment display driver that consumes the BCD digit outputs of the stopwatch (digit0..digit3) and drives the board's common-anode display.
- Cycles one digit at a time at a parameterised refresh rate.
- Snapshots all four digits at each frame start so one frame never mixes old and new counts.
- Inserts a ghosting guard band at every digit switch.

Parameters:
- COUNT_BITS, 17, width of the refresh tick counter.
- REFRESH_TICKS, 100000, clk cycles each digit is selected (1 kHz per digit at 100 MHz); must be 2 or more and fit in COUNT_BITS.
- BLANK_TICKS, 2, cycles at the start of each digit slot with all anodes off; must be less than REFRESH_TICKS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- digit0  input  4  BCD ones digit, rightmost, shown on anode[0].
- digit1  input  4  BCD digit shown on anode[1].
- digit2  input  4  BCD digit shown on anode[2].
- digit3  input  4  BCD digit, leftmost, shown on anode[3].
- dp_mask  input  4  active-high; bit i lights the decimal point while digit i is shown; sampled with the digits.
- anode  output  4  active-low digit enables.
- segment  output  7  active-low segments, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
- dp  output  1  active-low decimal point.
- frame_start  output  1  one-cycle pulse marking the start of each 4-digit frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - tick_count=0, digit_sel=0.
  - Snapshot registers (4x4 digits, 4-bit dp) cleared to 0.
  - anode=4'hF, segment=7'h7F, dp=1, frame_start=0.
- tick_count counts 0..REFRESH_TICKS-1 and wraps to 0.
- On the edge where tick_count=REFRESH_TICKS-1, digit_sel advances 0->1->2->3->0.
- On the edge where tick_count=REFRESH_TICKS-1 and digit_sel=3:
  - the snapshot loads digit0..3 and dp_mask;
  - frame_start is high for the single following cycle, coincident with digit_sel=0 and tick_count=0.
- The first frame after reset shows the cleared snapshot, i.e. 0000 with no decimal points.
- All outputs are registered. Pin values in cycle N+1 reflect digit_sel, tick_count and the snapshot in cycle N (one-cycle latency).
- Guard band: while tick_count < BLANK_TICKS, anode=4'hF, segment=7'h7F and dp=1.
- Outside the guard band:
  - anode has only bit digit_sel low;
  - segment is the decode of the snapshot digit selected by digit_sel;
  - dp = ~snapshot_dp[digit_sel].
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19;
  - 5=12, 6=02, 7=78, 8=00, 9=10.
- Invalid BCD (10-15) displays a dash: segment=7'h3F (g only).
- Input digit changes mid-frame have no effect until the next snapshot.
- Reset asserted mid-frame immediately forces all outputs to their reset values. After release, counting restarts at digit_sel=0, tick_count=0.
- No enable input: the block free-runs whenever reset=1.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: leading-zero suppression is evaluated on the snapshot.
  - digit3 is blanked if it is 0.
  - digit2 is blanked if it and digit3 are 0.
  - digit1 is blanked if it, digit2 and digit3 are 0.
  - digit0 is never blanked.
  - A blanked slot holds anode=4'hF, segment=7'h7F and dp=1 for its whole duration; frame timing is unchanged.
- Undefined: every digit is always displayed, including leading zeros.

Test Plan:
- Bench parameters for all scenarios: REFRESH_TICKS=8, BLANK_TICKS=2.
- Reset check: hold reset=0 for 5 cycles mid-count -> anode=F, segment=7F, dp=1, frame_start=0 throughout. First frame after release shows 0000 (segment=40 on each anode).
- Frame snapshot and timing: digits 3,2,1,0 = 5,9,0,7, dp_mask=4'b0100 before the first frame_start.
  - frame_start pulses every 32 cycles.
  - In frame 2, anode cycles E,D,B,7 with segment 78,40,10,12.
  - dp=0 only while anode=B.
  - Each slot starts with 2 cycles of anode=F.
- Tearing: change digit0 from 7 to 3 while anode=D in frame 2 -> frame 2 still shows 78 on anode=E; frame 3 shows 30.
- Invalid BCD: digit1=4'hC -> segment=3F during the anode=D slot.
- LEADING_ZERO_BLANK_EN defined, digits 3,2,1,0 = 0,0,4,0:
  - anode=7 and anode=B slots stay F for all 8 cycles;
  - anode=D shows 19 and anode=E shows 40.
  - Without the macro: anode=7 and anode=B slots show 40.
- Reset mid-operation: assert reset while digit_sel=2, tick_count=5 -> outputs go to reset values asynchronously, before the next clk edge. After release, the first frame_start arrives 32 cycles after restart.
